// File: rtl/irq_ctrl.sv
// Interrupt source controller: timer + external lines, masked
// fixed-priority arbitration, one request outstanding until eret.
module irq_ctrl #(
  parameter int NUM_EXT = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EXT-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic               int_ack,
  input  logic               eret,
  output logic               int_req,
  output logic [31:0]        int_cause,
  output logic               busy
);

  localparam int P = NUM_EXT + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_t;

  state_t state, state_n;

  logic [P-1:0]       mask;
  logic [P-1:0]       pending;
  logic [P-1:0]       pending_n;
  logic [P-1:0]       eligible;
  logic [P-1:0]       set_bits;
  logic [P-1:0]       clr_bits;
  logic [CNT_W-1:0]   compare;
  logic [CNT_W-1:0]   count;
  logic               ten;
  logic [NUM_EXT-1:0] irq_q;
  logic [2:0]         id;
  logic [2:0]         id_n;
  logic [2:0]         win;
  logic               tick_en;
  logic               fire;
  logic               ack_ok;
  logic               wr_mask;
  logic               wr_cmp;
  logic               wr_ten;
  logic               wr_w1c;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  always_comb begin
    wr_mask = 1'b0;
    wr_cmp  = 1'b0;
    wr_ten  = 1'b0;
    wr_w1c  = 1'b0;
    unique case (cfg_addr)
      2'd0:    wr_mask = cfg_we;
      2'd1:    wr_cmp  = cfg_we;
      2'd2:    wr_ten  = cfg_we;
      default: wr_w1c  = cfg_we;
    endcase
  end

  assign tick_en = ten && (compare != '0);
  assign fire    = tick_en && (count == compare);
  assign ack_ok  = (state == REQ) && int_ack;

  // Sets are applied after clears so a same-cycle edge wins.
  assign set_bits  = {irq_in & ~irq_q, fire};
  assign clr_bits  = (ack_ok ? (P'(1) << id) : '0)
                   | (wr_w1c ? P'(cfg_wdata) : '0);
  assign pending_n = (pending & ~clr_bits) | set_bits;
  assign eligible  = pending & mask;

  always_comb begin
    win = '0;
    for (int i = P - 1; i >= 0; i--) begin
      if (eligible[i]) win = 3'(i);
    end
  end

  always_comb begin
    state_n = state;
    id_n    = id;
    unique case (state)
      IDLE: begin
        if (|eligible) begin
          state_n = REQ;
          id_n    = win;
        end
      end
      REQ:     if (int_ack) state_n = SVC;
      SVC:     if (eret) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      id      <= '0;
      pending <= '0;
      irq_q   <= '0;
      mask    <= '0;
      compare <= '0;
      ten     <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_n;
      id      <= id_n;
      pending <= pending_n;
      irq_q   <= irq_in;
      if (wr_mask) mask <= P'(cfg_wdata);
      if (wr_ten) ten <= cfg_wdata[0];
      if (wr_cmp) begin
        compare <= CNT_W'(cfg_wdata);
        count   <= '0;
      end else if (tick_en) begin
        count <= fire ? '0 : count + CNT_W'(1);
      end
    end
  end

  assign int_req   = (state == REQ);
  assign busy      = (state == SVC);
  assign int_cause = int_req ? (32'(1) << ({2'b00, id} + 5'd2)) : '0;

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      2'd0:    cfg_rdata = 32'(mask);
      2'd1:    cfg_rdata = 32'(compare);
      2'd2:    cfg_rdata = {31'b0, ten};
      default: cfg_rdata = 32'(pending);
    endcase
  end

endmodule
